mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Main control unit for the multi-cycle MIPS datapath. It replaces hand-driven switch control with an FSM that decodes the instruction register opcode and funct fields and emits every datapath control strobe per cycle. It sits beside the datapath and consumes instruction[31:26], instruction[5:0] and the ALU zero flag. A run input gates instruction starts so the board can single-step from a key.

Parameters:
PC_WR_ON_RESET, 0, 1 = assert pc_wr during the first FETCH after reset. At 0 the first fetch still occurs; this only mirrors legacy debug.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; FSM to FETCH
run  input  1  level; sampled only in FETCH, 1 = start next instruction
opcode  input  6  instruction[31:26] from IR
funct  input  6  instruction[5:0] from IR
zero  input  1  ALU equality flag, valid when alu_op=111
pc_wr  output  1  PC write enable
iord  output  1  0 = PC addresses memory, 1 = ALU hold register
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
ir_write  output  1  IR load enable
mem_to_reg  output  1  1 = MDR to register file, 0 = ALU hold
reg_write  output  1  register file write enable
reg_dst  output  1  1 = rd, 0 = rt
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext, 11 = sign-ext<<2
alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 111 BEQ-compare
pc_source  output  2  00 = ALU out, 01 = ALU hold, 10 = jump address
state  output  4  current state encoding, for LED debug
instr_done  output  1  one-cycle pulse in the final state of each instruction
illegal  output  1  sticky; undefined opcode or funct was decoded

Behaviour:
- Reset (async): state=FETCH; all outputs 0; illegal=0.
- State register only. Outputs are a Moore decode of state, except pc_wr in BRANCH, which equals zero.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12.
- FETCH with run=0: all strobes 0; the FSM holds.
- FETCH with run=1: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, pc_wr=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into hold). Next state by opcode:
  - 000000 to R_EXEC
  - 100011 (lw) or 101011 (sw) to MEM_ADDR
  - 000100 to BRANCH
  - 000010 to JUMP
  - 001000 to ADDI_EXEC
  - anything else to TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: ALU controls as MEM_ADDR, iord=1, mem_read=1. Next MEM_WB.
- MEM_WB: ALU and memory controls as MEM_RD, mem_to_reg=1, reg_dst=0, reg_write=1, instr_done=1. Next FETCH.
- MEM_WR: ALU controls as MEM_ADDR, iord=1, mem_write=1, instr_done=1. Next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR. Any other funct goes to TRAP. Otherwise next R_WB.
- R_WB: ALU controls held equal to R_EXEC so the hold register is stable. reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next ADDI_WB.
- ADDI_WB: ALU controls held, reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=111, pc_source=01, pc_wr=zero, instr_done=1. Next FETCH.
- JUMP: pc_source=10, pc_wr=1, instr_done=1. Next FETCH.
- TRAP: all strobes 0, illegal=1. Held until reset; run is ignored.
- Latency in cycles: R 4, lw 5, sw 4, beq 3, j 3, addi 4.
- run is sampled only in FETCH. Deasserting run mid-instruction does not stall; the instruction completes.
- Reset mid-instruction aborts immediately; no partial write strobe is issued after reset asserts.
- mem_write and reg_write are never both 1. pc_wr is 1 only in FETCH, JUMP, or BRANCH with zero=1.

Optional Feature:
MC_PERF_COUNTERS_EN:
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every clock when state is not (FETCH with run=0) and not TRAP.
  - instr_cnt increments on instr_done.
  - Both wrap at 2^32-1 to 0.
- Undefined: ports and logic are absent.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct localparams
  - ALU op codes, alu_src_b codes, pc_source codes
- Sub-module mc_alu_decode: combinational funct to alu_op plus a funct_illegal flag. Instantiated once.

Test Plan:
- Reset, run=0 for 5 cycles -> state=0, every strobe 0, pc_wr never 1.
- run=1, opcode=000000, funct=100000 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4; instr_done pulses once.
- opcode=100011 -> states 0,1,2,3,4; cycle 5 has mem_to_reg=1, reg_write=1, iord=1. opcode=101011 -> 0,1,2,5 with mem_write=1 in cycle 4.
- opcode=000100 with zero=1 -> pc_wr=1, pc_source=01 in BRANCH. Repeat with zero=0 -> pc_wr=0 in BRANCH, next state FETCH.
- opcode=111111 -> TRAP after DECODE, illegal=1 persists with run toggling. Same for R-type funct=000111. Reset clears illegal.
- Async reset asserted in MEM_RD -> state=0 and all strobes 0 within the same cycle. With MC_PERF_COUNTERS_EN, running one add then one j gives instr_cnt=2, cycle_cnt=7.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : Shared encodings for the multi-cycle MIPS control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_BEQ = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_HOLD = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_alu_decode.sv
// ============================================================================
// Module  : mc_alu_decode
// Brief   : R-type funct field to ALU operation, flags unsupported functs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_illegal
);

    always_comb begin
        alu_op        = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module  : mc_control_fsm
// Brief   : Multi-cycle MIPS main control FSM; MC_PERF_COUNTERS_EN adds
//           cycle/instruction counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int PC_WR_ON_RESET = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     r_state;
    logic       r_first_fetch;
    logic [2:0] w_funct_alu_op;
    logic       w_funct_illegal;

    mc_alu_decode u_alu_decode (
        .funct         (funct),
        .alu_op        (w_funct_alu_op),
        .funct_illegal (w_funct_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:     if (run) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     r_state <= S_R_EXEC;
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDI_EXEC;
                        default:      r_state <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:    r_state <= S_MEM_WB;
                S_R_EXEC:    r_state <= w_funct_illegal ? S_TRAP : S_R_WB;
                S_ADDI_EXEC: r_state <= S_ADDI_WB;
                S_TRAP:      r_state <= S_TRAP;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Marks the first cycle after reset release for the legacy debug pc_wr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_first_fetch <= 1'b1;
        else       r_first_fetch <= 1'b0;
    end

    assign state = r_state;

    // Reset gates the decode so no strobe survives an abort, even with run high.
    always_comb begin
        pc_wr      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        mem_read  = 1'b1;
                        ir_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        pc_wr     = 1'b1;
                    end
                    if ((PC_WR_ON_RESET != 0) && r_first_fetch) pc_wr = 1'b1;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SL2;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD, S_MEM_WB: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    iord       = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = (r_state == S_MEM_WB);
                    reg_write  = (r_state == S_MEM_WB);
                    instr_done = (r_state == S_MEM_WB);
                end
                S_MEM_WR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_R_EXEC, S_R_WB: begin
                    alu_src_a  = 1'b1;
                    alu_op     = w_funct_alu_op;
                    reg_dst    = (r_state == S_R_WB);
                    reg_write  = (r_state == S_R_WB);
                    instr_done = (r_state == S_R_WB);
                end
                S_ADDI_WB: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_BEQ;
                    pc_source  = PCSRC_HOLD;
                    pc_wr      = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = PCSRC_JUMP;
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (!((r_state == S_FETCH) && !run) && (r_state != S_TRAP))
                cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module  : tb_mc_control_fsm
// Brief   : Directed self-checking bench for mc_control_fsm.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_write, reg_dst, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [21:0] exp_v [$];

    mc_control_fsm #(.PC_WR_ON_RESET(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_wr      (pc_wr),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [21:0] obs = {state, pc_wr, iord, mem_read, mem_write, ir_write, mem_to_reg,
                       reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
                       instr_done, illegal};

    function automatic logic [21:0] ov(
        input logic [3:0] st, input logic pw, io, mr, mw, irw, m2r, rw, rd, asa,
        input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] pcs,
        input logic dn, il);
        return {st, pw, io, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, dn, il};
    endfunction

    // Hand-written per-state expectations
    wire [21:0] V_F1   = ov(4'd0, H,L,H,L,H,L,L,L,L, 2'b01, 3'b000, 2'b00, L,L);
    wire [21:0] V_F0   = 22'd0;
    wire [21:0] V_DEC  = ov(4'd1, L,L,L,L,L,L,L,L,L, 2'b11, 3'b000, 2'b00, L,L);
    wire [21:0] V_TRAP = ov(4'd12, L,L,L,L,L,L,L,L,L, 2'b00, 3'b000, 2'b00, L,H);

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; opcode = 6'b0; funct = 6'b100000; zero = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, V_F0);
        end
        run = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== V_F0) begin
                n_fail++; $display("FAIL idle_cyc%0d: got %h expected %h", c, obs, V_F0);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [5];
        logic [2:0] ao [5];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
        ao = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int k = 0; k < 5; k++) begin
            exp_v.delete();
            exp_v.push_back(V_F1);
            exp_v.push_back(V_DEC);
            exp_v.push_back(ov(4'd6, L,L,L,L,L,L,L,L,H, 2'b00, ao[k], 2'b00, L,L));
            exp_v.push_back(ov(4'd7, L,L,L,L,L,L,H,H,H, 2'b00, ao[k], 2'b00, H,L));
            exp_v.push_back(V_F0);
            run = 1'b1; opcode = 6'b000000; funct = fn[k];
            for (int c = 0; c < exp_v.size(); c++) begin
                if (c > 0) begin @(posedge clk); #1; run = 1'b0; end
                #1;
                n_checks++;
                if (obs !== exp_v[c]) begin
                    n_fail++;
                    $display("FAIL rtype_f%0d_cyc%0d: got %h expected %h", k, c, obs, exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_mem();
        for (int k = 0; k < 2; k++) begin
            exp_v.delete();
            exp_v.push_back(V_F1);
            exp_v.push_back(V_DEC);
            exp_v.push_back(ov(4'd2, L,L,L,L,L,L,L,L,H, 2'b10, 3'b000, 2'b00, L,L));
            if (k == 0) begin
                exp_v.push_back(ov(4'd3, L,H,H,L,L,L,L,L,H, 2'b10, 3'b000, 2'b00, L,L));
                exp_v.push_back(ov(4'd4, L,H,H,L,L,H,H,L,H, 2'b10, 3'b000, 2'b00, H,L));
            end else begin
                exp_v.push_back(ov(4'd5, L,H,L,H,L,L,L,L,H, 2'b10, 3'b000, 2'b00, H,L));
            end
            exp_v.push_back(V_F0);
            run = 1'b1; opcode = (k == 0) ? 6'b100011 : 6'b101011;
            for (int c = 0; c < exp_v.size(); c++) begin
                if (c > 0) begin @(posedge clk); #1; run = 1'b0; end
                #1;
                n_checks++;
                if (obs !== exp_v[c]) begin
                    n_fail++;
                    $display("FAIL mem_%s_cyc%0d: got %h expected %h",
                             (k == 0) ? "lw" : "sw", c, obs, exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_branch_jump_addi();
        for (int k = 0; k < 4; k++) begin
            exp_v.delete();
            exp_v.push_back(V_F1);
            exp_v.push_back(V_DEC);
            case (k)
                0: exp_v.push_back(ov(4'd8, H,L,L,L,L,L,L,L,H, 2'b00, 3'b111, 2'b01, H,L));
                1: exp_v.push_back(ov(4'd8, L,L,L,L,L,L,L,L,H, 2'b00, 3'b111, 2'b01, H,L));
                2: exp_v.push_back(ov(4'd9, H,L,L,L,L,L,L,L,L, 2'b00, 3'b000, 2'b10, H,L));
                default: begin
                    exp_v.push_back(ov(4'd10, L,L,L,L,L,L,L,L,H, 2'b10, 3'b000, 2'b00, L,L));
                    exp_v.push_back(ov(4'd11, L,L,L,L,L,L,H,L,H, 2'b10, 3'b000, 2'b00, H,L));
                end
            endcase
            exp_v.push_back(V_F0);
            run = 1'b1;
            zero = (k == 0);
            opcode = (k < 2) ? 6'b000100 : (k == 2) ? 6'b000010 : 6'b001000;
            for (int c = 0; c < exp_v.size(); c++) begin
                if (c > 0) begin @(posedge clk); #1; run = 1'b0; end
                #1;
                n_checks++;
                if (obs !== exp_v[c]) begin
                    n_fail++;
                    $display("FAIL ctl_case%0d_cyc%0d: got %h expected %h", k, c, obs, exp_v[c]);
                end
            end
            zero = 1'b0;
        end
    endtask

    task automatic test_trap();
        for (int k = 0; k < 2; k++) begin
            run = 1'b1;
            opcode = (k == 0) ? 6'b111111 : 6'b000000;
            funct  = 6'b000111;
            #1;
            n_checks++;
            if (obs !== V_F1) begin
                n_fail++; $display("FAIL trap%0d_fetch: got %h expected %h", k, obs, V_F1);
            end
            @(posedge clk); #1; run = 1'b0;
            if (k == 1) begin
                @(posedge clk); #1;
                n_checks++;
                if (state !== 4'd6) begin
                    n_fail++; $display("FAIL trap1_rexec: state got %0d expected 6", state);
                end
            end
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                run = c[0];
                #1;
                n_checks++;
                if (obs !== V_TRAP) begin
                    n_fail++; $display("FAIL trap%0d_hold%0d: got %h expected %h", k, c, obs, V_TRAP);
                end
            end
            reset = 1'b1; #1;
            n_checks++;
            if (obs !== V_F0) begin
                n_fail++; $display("FAIL trap%0d_reset: got %h expected %h", k, obs, V_F0);
            end
            run = 1'b0;
            @(posedge clk); #1; reset = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== V_F0) begin
                n_fail++; $display("FAIL trap%0d_cleared: got %h expected %h", k, obs, V_F0);
            end
        end
    endtask

    task automatic test_async_reset();
        run = 1'b1; opcode = 6'b100011;
        @(posedge clk); #1; run = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (obs !== ov(4'd3, L,H,H,L,L,L,L,L,H, 2'b10, 3'b000, 2'b00, L,L)) begin
            n_fail++; $display("FAIL arst_pre: got %h expected state 3 vector", obs);
        end
        run = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++; $display("FAIL arst_abort: got %h expected %h", obs, V_F0);
        end
        run = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== V_F0) begin
            n_fail++; $display("FAIL arst_after: got %h expected %h", obs, V_F0);
        end
    endtask

`ifdef MC_PERF_COUNTERS_EN
    task automatic test_perf();
        reset = 1'b1; run = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        run = 1'b1; opcode = 6'b000000; funct = 6'b100000;
        repeat (4) @(posedge clk);
        #1; opcode = 6'b000010;
        repeat (3) @(posedge clk);
        #1; run = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (instr_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_instr: got %0d expected 2", instr_cnt);
        end
        n_checks++;
        if (cycle_cnt !== 32'd7) begin
            n_fail++; $display("FAIL perf_cycle: got %0d expected 7", cycle_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump_addi();
        test_trap();
        test_async_reset();
`ifdef MC_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
